miner_work_sched: RTL and testbench
===================================

// Module: miner_work_sched
// PURPOSE
//  Work scheduler and result collector for one sha256_top miner core.
//  - Double-buffers incoming jobs (midstate+data2) and sequences start_mining.
//  - Captures golden nonces into a small FIFO for the host interface.
//  - Sits between the host command decoder and the sha256_top instance.
// PARAMETERS
//  FIFO_DEPTH   4      nonce FIFO entries (power of 2, >=2)
//  BUSY_WAIT    16     cycles to wait for miner_busy after start before retrying start
//  PREEMPT      1      1: new work aborts running job; 0: new work queues until job done
// PORTS
//  clk            in   1    system clock
//  rst            in   1    async reset, active-high
//  work_valid     in   1    host offers job
//  work_ready     out  1    pending slot empty, job accepted when valid&ready
//  work_midstate  in   256  job midstate
//  work_data2     in   96   job data2 (tail of header)
//  midstate       out  256  to miner, held stable for job duration
//  data2          out  96   to miner, held stable for job duration
//  start_mining   out  1    one-cycle start pulse to miner
//  miner_busy     in   1    miner running
//  got_ticket     in   1    miner found nonce
//  golden_nonce   in   32   nonce from miner, valid with got_ticket
//  nonce_valid    out  1    FIFO not empty
//  nonce_data     out  32   FIFO head
//  nonce_ready    in   1    pop when valid&ready
//  nonce_ovf      out  1    sticky: a nonce was dropped on full FIFO; cleared by rst only
//  sched_idle     out  1    FSM in IDLE and no pending job
// BEHAVIOUR
//  Reset: all outputs 0 except work_ready=1, sched_idle=1; FIFO empty; FSM IDLE.
//  Pending slot: written on work_valid&work_ready; work_ready=~pend_vld.
//   Slot freed in LOAD; accept and free in same cycle -> new job kept (pend_vld stays 1).
//  FSM:
//   IDLE  : pend_vld -> LOAD.
//   LOAD  : midstate/data2 <= slot; pend_vld cleared -> START.
//   START : start_mining=1 for exactly this cycle; cnt<=0 -> WAITB.
//   WAITB : miner_busy -> RUN; else cnt++; cnt==BUSY_WAIT-1 -> START (retry, unbounded).
//   RUN   : miner_busy falls -> (pend_vld ? LOAD : IDLE).
//           PREEMPT=1 and pend_vld -> LOAD immediately (restart overrides miner).
//  Latency: accept in IDLE -> start_mining asserted 2 cycles later (LOAD, START).
//  midstate/data2 change only in LOAD; never while start_mining high.
//  Nonce capture: push golden_nonce on rising edge of got_ticket (registered prev value);
//   a level held high pushes once. Captured in any state (late tickets after
//   preempt still stored).
//  FIFO: push and pop same cycle when full -> both succeed, count unchanged;
//   push when full without pop -> dropped, nonce_ovf<=1. Pointers wrap mod FIFO_DEPTH.
//   nonce_data is FIFO head (combinational read of registered array).
//  Reset mid-job: FSM to IDLE, pending and FIFO discarded, start_mining deasserted async.
// CONFIGURATION
//  WORK_TAG_EN defined: extra ports work_tag in 8 (sampled with job) and nonce_tag out 8;
//   the tag of the job active at capture travels with each FIFO entry.
//  Not defined: ports absent, FIFO 32 bits wide; behaviour otherwise identical.
// TESTING
//  1 Job A offered in IDLE, miner_busy high 3 cycles after start -> start pulse 2 cycles
//    after accept, single cycle, midstate=A.midstate, FSM RUN.
//  2 miner_busy never rises, BUSY_WAIT=16 -> start_mining re-pulses every 17 cycles.
//  3 PREEMPT=1, job B accepted while A runs -> LOAD next cycle, midstate=B, new start pulse;
//    PREEMPT=0 -> B loaded only after miner_busy falls.
//  4 got_ticket held high 5 cycles, golden_nonce=32'hDEADBEEF -> exactly one entry,
//    nonce_data=32'hDEADBEEF.
//  5 FIFO_DEPTH=4, 5 tickets, nonce_ready=0 -> 4 entries kept in order, nonce_ovf=1;
//    full + push + pop same cycle -> no drop.
//  6 rst asserted in RUN with 2 FIFO entries -> nonce_valid=0, work_ready=1, sched_idle=1.

Source files
------------

// File: rtl/miner_work_sched.sv
// miner_work_sched: job double-buffer, start sequencer and golden-nonce FIFO
// for one sha256_top miner core.
// Optional build macro WORK_TAG_EN: adds work_tag/nonce_tag ports. Each FIFO entry
// then carries the tag of the job that was active when the nonce was captured.
//
// state  | meaning
// IDLE   | no job loaded into the miner, waiting for a pending job
// LOAD   | copy pending slot to midstate/data2 outputs, free the slot
// START  | one-cycle start_mining pulse, clear busy-wait counter
// WAITB  | wait for miner_busy; retry START after BUSY_WAIT cycles
// RUN    | miner working; leave on busy fall (or on new work if PREEMPT)
module miner_work_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_WAIT  = 16,
  parameter bit PREEMPT    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data2,
`ifdef WORK_TAG_EN
  input  logic [7:0]   work_tag,
  output logic [7:0]   nonce_tag,
`endif
  output logic [255:0] midstate,
  output logic [95:0]  data2,
  output logic         start_mining,
  input  logic         miner_busy,
  input  logic         got_ticket,
  input  logic [31:0]  golden_nonce,
  output logic         nonce_valid,
  output logic [31:0]  nonce_data,
  input  logic         nonce_ready,
  output logic         nonce_ovf,
  output logic         sched_idle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
`ifdef WORK_TAG_EN
  localparam int FW = 40;
`else
  localparam int FW = 32;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAITB, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          pend_vld;
  logic [255:0]  pend_mid;
  logic [95:0]   pend_d2;
  logic          accept;
  logic          pend_any;

  logic          tkt_q;
  logic          push_req;
  logic          do_push;
  logic          do_pop;
  logic          fifo_full;
  logic [FW-1:0] push_data;
  logic [FW-1:0] head;
  logic [FW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;

`ifdef WORK_TAG_EN
  logic [7:0]    pend_tag;
  logic [7:0]    cur_tag;
`endif

  assign work_ready = ~pend_vld;
  assign accept     = work_valid & work_ready;
  // A job accepted this cycle counts as pending so LOAD follows immediately.
  assign pend_any   = pend_vld | accept;

  // Pending job slot: filled on handshake, emptied when LOAD copies it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_mid <= '0;
      pend_d2  <= '0;
`ifdef WORK_TAG_EN
      pend_tag <= '0;
`endif
    end else if (accept) begin
      pend_vld <= 1'b1;
      pend_mid <= work_midstate;
      pend_d2  <= work_data2;
`ifdef WORK_TAG_EN
      pend_tag <= work_tag;
`endif
    end else if (state == S_LOAD) begin
      pend_vld <= 1'b0;
    end
  end

  // FSM state and busy-wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:  if (pend_any) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: begin
        cnt_nxt   = '0;
        state_nxt = S_WAITB;
      end
      S_WAITB: begin
        if (miner_busy)            state_nxt = S_RUN;
        else if (cnt == CNT_LAST)  state_nxt = S_START;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      S_RUN: begin
        if (PREEMPT && pend_any)   state_nxt = S_LOAD;
        else if (!miner_busy)      state_nxt = pend_any ? S_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded from the state register so reset clears the pulse asynchronously.
  assign start_mining = (state == S_START);
  assign sched_idle   = (state == S_IDLE) & ~pend_vld;

  // Job outputs to the miner only change in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      midstate <= '0;
      data2    <= '0;
`ifdef WORK_TAG_EN
      cur_tag  <= '0;
`endif
    end else if (state == S_LOAD) begin
      midstate <= pend_mid;
      data2    <= pend_d2;
`ifdef WORK_TAG_EN
      cur_tag  <= pend_tag;
`endif
    end
  end

  // Ticket edge detector: a held level yields a single capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tkt_q <= 1'b0;
    else     tkt_q <= got_ticket;
  end

  assign push_req  = got_ticket & ~tkt_q;
  assign fifo_full = (fifo_cnt == CNT_FULL);
  assign do_pop    = nonce_ready & nonce_valid;
  // A pop in the same cycle makes room, so full+push+pop does not drop.
  assign do_push   = push_req & (~fifo_full | do_pop);
`ifdef WORK_TAG_EN
  assign push_data = {cur_tag, golden_nonce};
`else
  assign push_data = golden_nonce;
`endif

  // Nonce FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      nonce_ovf <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !do_push) nonce_ovf <= 1'b1;
    end
  end

  assign head        = fifo_mem[rd_ptr];
  assign nonce_valid = (fifo_cnt != '0);
  assign nonce_data  = head[31:0];
`ifdef WORK_TAG_EN
  assign nonce_tag   = head[39:32];
`endif

endmodule

// File: tb/tb_miner_work_sched.sv
// tb_miner_work_sched: directed scenarios followed by a randomized run, with
// job and nonce scoreboards fed from the stimulus and checked by monitors.
module tb_miner_work_sched;
  localparam int FIFO_DEPTH = 4;
  localparam int BUSY_WAIT  = 16;

  logic         clk, rst;
  logic         work_valid, work_ready;
  logic [255:0] work_midstate, midstate;
  logic [95:0]  work_data2, data2;
  logic         start_mining, miner_busy, got_ticket;
  logic [31:0]  golden_nonce, nonce_data;
  logic         nonce_valid, nonce_ready, nonce_ovf, sched_idle;
`ifdef WORK_TAG_EN
  logic [7:0]   work_tag, nonce_tag;
  assign work_tag = 8'h00;
`endif

  int checks = 0;
  int failures = 0;
  int miner_mode = 1;  // 0 random, 1 always answer (delay 3, run 30), 2 never answer
  bit rnd_en = 0;

  miner_work_sched #(.FIFO_DEPTH(FIFO_DEPTH), .BUSY_WAIT(BUSY_WAIT), .PREEMPT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data2(work_data2),
`ifdef WORK_TAG_EN
    .work_tag(work_tag), .nonce_tag(nonce_tag),
`endif
    .midstate(midstate), .data2(data2), .start_mining(start_mining),
    .miner_busy(miner_busy), .got_ticket(got_ticket), .golden_nonce(golden_nonce),
    .nonce_valid(nonce_valid), .nonce_data(nonce_data), .nonce_ready(nonce_ready),
    .nonce_ovf(nonce_ovf), .sched_idle(sched_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Miner model: reacts to each start pulse by raising busy after a delay, or never.
  initial begin
    int dly; int run_left; bit st;
    miner_busy = 1'b0; dly = 0; run_left = 0;
    forever begin
      @(negedge clk); st = start_mining;
      @(posedge clk); #1;
      if (rst) begin
        miner_busy = 1'b0; dly = 0; run_left = 0;
      end else if (st) begin
        miner_busy = 1'b0; run_left = 0;
        if (miner_mode == 2 || (miner_mode == 0 && $urandom_range(3) == 0)) dly = 0;
        else dly = (miner_mode == 1) ? 3 : int'($urandom_range(1, 3));
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          miner_busy = 1'b1;
          run_left = (miner_mode == 1) ? 30 : int'($urandom_range(2, 20));
        end
      end else if (miner_busy) begin
        run_left--;
        if (run_left == 0) miner_busy = 1'b0;
      end
    end
  end

  // Job scoreboard: accepted jobs in order; an unanswered start must be a retry
  // of the same job exactly BUSY_WAIT+1 cycles later, an answered one moves on.
  logic [351:0] jq[$];
  logic [351:0] cur_job;
  bit seen_busy, prev_start;
  int cyc = 0, last_pulse = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      jq.delete(); seen_busy = 1'b1; prev_start = 1'b0; cur_job = '0;
    end else begin
      if (work_valid && work_ready) jq.push_back({work_midstate, work_data2});
      if (miner_busy) seen_busy = 1'b1;
      if (start_mining) begin
        chk("start_single_cycle", prev_start, 1'b0);
        if (seen_busy) begin
          chk("start_has_job", jq.size() != 0, 1'b1);
          if (jq.size() != 0) begin
            cur_job = jq.pop_front();
            chk("job_midstate", midstate, cur_job[351:96]);
            chk("job_data2", data2, cur_job[95:0]);
          end
        end else begin
          chk("retry_midstate", midstate, cur_job[351:96]);
          chk("retry_gap", cyc - last_pulse, BUSY_WAIT + 1);
        end
        seen_busy = 1'b0;
        last_pulse = cyc;
      end
      prev_start = start_mining;
    end
  end

  // Nonce scoreboard: rising-edge capture into a bounded queue, pop first.
  logic [31:0] nq[$];
  bit n_prev, exp_ovf;
  always @(negedge clk) begin
    if (rst) begin
      nq.delete(); n_prev = 1'b0; exp_ovf = 1'b0;
    end else begin
      chk("nonce_valid", nonce_valid, nq.size() != 0);
      chk("nonce_ovf", nonce_ovf, exp_ovf);
      if (nq.size() != 0) begin
        chk("nonce_head", nonce_data, nq[0]);
        if (nonce_ready) void'(nq.pop_front());
      end
      if (got_ticket && !n_prev) begin
        if (nq.size() < FIFO_DEPTH) nq.push_back(golden_nonce);
        else exp_ovf = 1'b1;
      end
      n_prev = got_ticket;
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = work_valid && work_ready;
    @(posedge clk); #1;
    if (acc) work_valid = 1'b0;
    if (rnd_en) begin
      if (!work_valid && $urandom_range(5) == 0) begin
        work_valid = 1'b1;
        for (int i = 0; i < 8; i++) work_midstate[i*32 +: 32] = $urandom;
        for (int i = 0; i < 3; i++) work_data2[i*32 +: 32] = $urandom;
      end
      if ($urandom_range(3) == 0) got_ticket = ~got_ticket;
      golden_nonce = $urandom;
      nonce_ready = ($urandom_range(2) == 0);
    end
  endtask

  task automatic ticks(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  // Offer one job and check start_mining appears 2 cycles after the accept cycle.
  task automatic offer_check(input logic [255:0] m, input logic [95:0] d);
    bit a = 1'b0;
    sync();
    work_midstate = m; work_data2 = d; work_valid = 1'b1;
    for (int i = 0; i < 200 && !a; i++) tick(a);
    chk("offer_accepted", a, 1'b1);
    @(negedge clk); chk("latency_cycle1", start_mining, 1'b0);
    @(negedge clk); chk("latency_cycle2", start_mining, 1'b1);
    @(negedge clk); chk("latency_cycle3", start_mining, 1'b0);
  endtask

  task automatic wait_busy();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = miner_busy; end
    chk("wait_busy_in_time", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin @(negedge clk); ok = sched_idle && !miner_busy; end
    chk("wait_idle_in_time", ok, 1'b1);
  endtask

  task automatic ticket(input logic [31:0] v);
    golden_nonce = v; got_ticket = 1'b1; ticks(1);
    got_ticket = 1'b0; ticks(1);
  endtask

  initial begin
    int npulse;
    rst = 1'b1; work_valid = 1'b0; work_midstate = '0; work_data2 = '0;
    got_ticket = 1'b0; golden_nonce = '0; nonce_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_work_ready", work_ready, 1'b1);
    chk("rst_sched_idle", sched_idle, 1'b1);
    chk("rst_start", start_mining, 1'b0);
    chk("rst_midstate", midstate, 256'h0);
    chk("rst_data2", data2, 96'h0);

    // Job A from IDLE, then job B preempts A while it runs.
    miner_mode = 1;
    offer_check({8{32'hA5A5_0001}}, {3{32'h0A0A_0001}});
    wait_busy();
    chk("run_sched_idle", sched_idle, 1'b0);
    chk("run_work_ready", work_ready, 1'b1);
    offer_check({8{32'hB0B0_0002}}, {3{32'h0B0B_0002}});
    wait_idle();

    // Miner never answers: start re-pulses every BUSY_WAIT+1 cycles.
    miner_mode = 2;
    offer_check({8{32'hC3C3_0003}}, {3{32'h0C0C_0003}});
    npulse = 0;
    for (int i = 0; i < 3 * (BUSY_WAIT + 1); i++) begin
      @(negedge clk);
      if (start_mining) npulse++;
    end
    chk("retry_pulse_count", npulse, 3);
    miner_mode = 1;
    wait_idle();

    // Held ticket captures once.
    sync();
    golden_nonce = 32'hDEADBEEF; got_ticket = 1'b1; ticks(5);
    got_ticket = 1'b0; golden_nonce = 32'h1234_5678; ticks(1);
    chk("held_ticket_valid", nonce_valid, 1'b1);
    chk("held_ticket_data", nonce_data, 32'hDEADBEEF);
    nonce_ready = 1'b1; ticks(1); nonce_ready = 1'b0;
    chk("held_ticket_single", nonce_valid, 1'b0);

    // Overflow on the fifth push, then full+push+pop keeps everything.
    for (int k = 0; k < 5; k++) ticket(32'hA000_0000 + k);
    chk("ovf_set", nonce_ovf, 1'b1);
    golden_nonce = 32'hA000_0005; got_ticket = 1'b1; nonce_ready = 1'b1; ticks(1);
    got_ticket = 1'b0; nonce_ready = 1'b0; ticks(1);
    chk("full_push_pop_head", nonce_data, 32'hA000_0001);
    nonce_ready = 1'b1; ticks(FIFO_DEPTH); nonce_ready = 1'b0;
    chk("drained_after_ovf", nonce_valid, 1'b0);

    // Reset while running with two stored nonces.
    ticket(32'h0000_0111);
    ticket(32'h0000_0222);
    offer_check({8{32'hD4D4_0004}}, {3{32'h0D0D_0004}});
    wait_busy();
    chk("pre_rst_valid", nonce_valid, 1'b1);
    sync();
    rst = 1'b1;
    #1;
    chk("mid_rst_nonce_valid", nonce_valid, 1'b0);
    chk("mid_rst_work_ready", work_ready, 1'b1);
    chk("mid_rst_sched_idle", sched_idle, 1'b1);
    chk("mid_rst_ovf_clear", nonce_ovf, 1'b0);
    chk("mid_rst_start", start_mining, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Randomized traffic on jobs, miner behaviour, tickets and pops.
    sync();
    miner_mode = 0; rnd_en = 1'b1;
    ticks(4000);
    rnd_en = 1'b0; got_ticket = 1'b0;
    for (int i = 0; i < 300 && work_valid; i++) ticks(1);
    chk("final_offer_taken", work_valid, 1'b0);
    miner_mode = 1;
    wait_idle();
    chk("all_jobs_started", jq.size(), 0);
    sync();
    nonce_ready = 1'b1; ticks(FIFO_DEPTH + 2); nonce_ready = 1'b0;
    chk("final_fifo_empty", nonce_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
